// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and helpers: packed complex access, rounding shift and saturation.
package fft_pkg;

  localparam int unsigned DATA_W_DEF  = 25;
  localparam int unsigned TW_W_DEF    = 18;
  localparam int unsigned TW_FRAC_DEF = 16;

  // Helpers work on a 64-bit signed scratch width; callers narrow the results.
  typedef logic signed [63:0]  wide_t;
  typedef logic        [127:0] cplx_t;

  function automatic wide_t sext(input logic [63:0] x, input int unsigned w);
    wide_t t;
    t = wide_t'(x << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic wide_t cplx_re(input cplx_t c, input int unsigned w);
    return sext(64'(c >> w), w);
  endfunction

  function automatic wide_t cplx_im(input cplx_t c, input int unsigned w);
    return sext(64'(c), w);
  endfunction

  function automatic cplx_t cplx_pack(input wide_t re, input wide_t im, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] ru;
    logic [63:0] iu;
    mask = (64'd1 << w) - 64'd1;
    ru   = re;
    iu   = im;
    return (cplx_t'(ru & mask) << w) | cplx_t'(iu & mask);
  endfunction

  // Round half up, then arithmetic shift right.
  function automatic wide_t round_shift(input wide_t x, input int unsigned sh);
    if (sh == 0) return x;
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic wide_t sat(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Pipelined full-precision complex multiplier p = a*b with a valid shadow pipeline.
module cmult_pipe #(
  parameter int unsigned A_W    = 26,
  parameter int unsigned B_W    = 18,
  parameter int unsigned STAGES = 3,
  localparam int unsigned P_W   = A_W + B_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a_re,
  input  logic signed [A_W-1:0] a_im,
  input  logic signed [B_W-1:0] b_re,
  input  logic signed [B_W-1:0] b_im,
  output logic                  out_valid,
  output logic signed [P_W-1:0] p_re,
  output logic signed [P_W-1:0] p_im
);

  logic signed [P_W-1:0] prod_re;
  logic signed [P_W-1:0] prod_im;
  logic signed [P_W-1:0] re_q [STAGES];
  logic signed [P_W-1:0] im_q [STAGES];
  logic [STAGES-1:0]     vld_q;

  // Product is formed up front; trailing registers are plain delay so the
  // multiplier can be retimed into them.
  always_comb begin
    prod_re = P_W'(a_re) * P_W'(b_re) - P_W'(a_im) * P_W'(b_im);
    prod_im = P_W'(a_re) * P_W'(b_im) + P_W'(a_im) * P_W'(b_re);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int unsigned i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      re_q[0] <= prod_re;
      im_q[0] <= prod_im;
      for (int unsigned i = 1; i < STAGES; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign p_re      = re_q[STAGES-1];
  assign p_im      = im_q[STAGES-1];

endmodule

// File: rtl/fft_r2_butterfly.sv
// Handshaked radix-2 DIF butterfly: X0 = a+b, X1 = (a-b)*w, with scaling and sticky saturation flag.
module fft_r2_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TW_W       = TW_W_DEF,
  parameter int unsigned TW_FRAC    = TW_FRAC_DEF,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [2*DATA_W-1:0]   s_a_i,
  input  logic [2*DATA_W-1:0]   s_b_i,
  input  logic [2*TW_W-1:0]     s_w_i,
  input  logic                  s_last_i,
  input  logic                  scale_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [2*DATA_W-1:0]   m_x0_o,
  output logic [2*DATA_W-1:0]   m_x1_o,
  output logic                  m_last_o,
  output logic                  ovf_o,
  input  logic                  clear_ovf_i
);

  localparam int unsigned D_W = DATA_W + 1;
  localparam int unsigned P_W = D_W + TW_W + 1;
  localparam int unsigned L   = MUL_STAGES - 1;

  logic en;
  assign en        = !m_valid_o || m_ready_i;
  assign s_ready_o = en;

  logic                  v0;
  logic                  last0;
  logic                  scale0;
  logic signed [D_W-1:0] sum_re0;
  logic signed [D_W-1:0] sum_im0;
  logic signed [D_W-1:0] dif_re0;
  logic signed [D_W-1:0] dif_im0;
  logic signed [TW_W-1:0] w_re0;
  logic signed [TW_W-1:0] w_im0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)  v0 <= 1'b0;
    else if (en) v0 <= s_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      sum_re0 <= D_W'(cplx_re(cplx_t'(s_a_i), DATA_W) + cplx_re(cplx_t'(s_b_i), DATA_W));
      sum_im0 <= D_W'(cplx_im(cplx_t'(s_a_i), DATA_W) + cplx_im(cplx_t'(s_b_i), DATA_W));
      dif_re0 <= D_W'(cplx_re(cplx_t'(s_a_i), DATA_W) - cplx_re(cplx_t'(s_b_i), DATA_W));
      dif_im0 <= D_W'(cplx_im(cplx_t'(s_a_i), DATA_W) - cplx_im(cplx_t'(s_b_i), DATA_W));
      w_re0   <= TW_W'(cplx_re(cplx_t'(s_w_i), TW_W));
      w_im0   <= TW_W'(cplx_im(cplx_t'(s_w_i), TW_W));
      last0   <= s_last_i;
      scale0  <= scale_i;
    end
  end

  logic                  mv;
  logic signed [P_W-1:0] p_re;
  logic signed [P_W-1:0] p_im;

  cmult_pipe #(
    .A_W    (D_W),
    .B_W    (TW_W),
    .STAGES (MUL_STAGES)
  ) u_cmult (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .en        (en),
    .in_valid  (v0),
    .a_re      (dif_re0),
    .a_im      (dif_im0),
    .b_re      (w_re0),
    .b_im      (w_im0),
    .out_valid (mv),
    .p_re      (p_re),
    .p_im      (p_im)
  );

  // Sum and sideband ride alongside the multiplier so both halves of a pair line up.
  logic signed [D_W-1:0] x0_re_d [MUL_STAGES];
  logic signed [D_W-1:0] x0_im_d [MUL_STAGES];
  logic                  last_d  [MUL_STAGES];
  logic                  scale_d [MUL_STAGES];

  always_ff @(posedge clk_i) begin
    if (en) begin
      x0_re_d[0] <= sum_re0;
      x0_im_d[0] <= sum_im0;
      last_d[0]  <= last0;
      scale_d[0] <= scale0;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        x0_re_d[i] <= x0_re_d[i-1];
        x0_im_d[i] <= x0_im_d[i-1];
        last_d[i]  <= last_d[i-1];
        scale_d[i] <= scale_d[i-1];
      end
    end
  end

  wide_t x0r, x0i, x1r, x1i;
  logic  sat_any;

  always_comb begin
    x0r = wide_t'(x0_re_d[L]);
    x0i = wide_t'(x0_im_d[L]);
    x1r = round_shift(wide_t'(p_re), TW_FRAC);
    x1i = round_shift(wide_t'(p_im), TW_FRAC);
    if (scale_d[L]) begin
      x0r = round_shift(x0r, 1);
      x0i = round_shift(x0i, 1);
      x1r = round_shift(x1r, 1);
      x1i = round_shift(x1i, 1);
    end
    sat_any = (sat(x0r, DATA_W) != x0r) || (sat(x0i, DATA_W) != x0i) ||
              (sat(x1r, DATA_W) != x1r) || (sat(x1i, DATA_W) != x1i);
  end

  logic sat_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      sat_q     <= 1'b0;
    end else if (en) begin
      m_valid_o <= mv;
      m_last_o  <= mv && last_d[L];
      sat_q     <= mv && sat_any;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      m_x0_o <= (2*DATA_W)'(cplx_pack(sat(x0r, DATA_W), sat(x0i, DATA_W), DATA_W));
      m_x1_o <= (2*DATA_W)'(cplx_pack(sat(x1r, DATA_W), sat(x1i, DATA_W), DATA_W));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   ovf_o <= 1'b0;
    else if (m_valid_o && sat_q)  ovf_o <= 1'b1;
    else if (clear_ovf_i)         ovf_o <= 1'b0;
  end

endmodule

// File: tb/tb_fft_r2_butterfly.sv
// Scoreboard bench for fft_r2_butterfly: directed vectors in, monitor compares outputs as they leave.
module tb_fft_r2_butterfly;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [49:0] s_a = '0;
  logic [49:0] s_b = '0;
  logic [35:0] s_w = '0;
  logic        s_last = 1'b0;
  logic        scale = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [49:0] m_x0;
  logic [49:0] m_x1;
  logic        m_last;
  logic        ovf;
  logic        clear_ovf = 1'b0;

  fft_r2_butterfly #(
    .DATA_W     (25),
    .TW_W       (18),
    .TW_FRAC    (16),
    .MUL_STAGES (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_a_i       (s_a),
    .s_b_i       (s_b),
    .s_w_i       (s_w),
    .s_last_i    (s_last),
    .scale_i     (scale),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_x0_o      (m_x0),
    .m_x1_o      (m_x1),
    .m_last_o    (m_last),
    .ovf_o       (ovf),
    .clear_ovf_i (clear_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [49:0] x0;
    logic [49:0] x1;
    logic        last;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [49:0] pk(input int re, input int im);
    logic [24:0] r;
    logic [24:0] i;
    r = re[24:0];
    i = im[24:0];
    return {r, i};
  endfunction

  function automatic logic [35:0] pw(input int re, input int im);
    logic [17:0] r;
    logic [17:0] i;
    r = re[17:0];
    i = im[17:0];
    return {r, i};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: sample at negedge, a transfer happens on the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (m_valid && !m_ready) chk("s_ready_stall", 64'(s_ready), 64'(0));
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=x0 %0h required=no output", m_x0);
          end else begin
            e = sbq.pop_front();
            chk("x0", 64'(m_x0), 64'(e.x0));
            chk("x1", 64'(m_x1), 64'(e.x1));
            chk("last", 64'(m_last), 64'(e.last));
            if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'(5));
          end
        end
      end
    end
  end

  task automatic send(input logic [49:0] a, input logic [49:0] b, input logic [35:0] w,
                      input logic last, input logic sc, input logic push, input logic lat,
                      input logic [49:0] x0e, input logic [49:0] x1e);
    int n;
    exp_t e;
    n = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_w = w;
    s_last = last;
    scale = sc;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("accept_timeout", 64'(s_ready), 64'(1));
    end else if (push) begin
      e.x0 = x0e;
      e.x1 = x1e;
      e.last = last;
      e.acc = cyc;
      e.chk_lat = lat;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    scale = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'(0));
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int t_are[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
  int t_aim[8] = '{-1, -2, -3, -4, -5, -6, -7, -8};
  int t_bre[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int t_bim[8] = '{2, 4, 6, 8, 10, 12, 14, 16};
  int t_wre[8] = '{65536, -65536, 0, 0, 65536, -65536, 0, 0};
  int t_wim[8] = '{0, 0, -65536, 65536, 0, 0, -65536, 65536};
  int t_0re[8] = '{11, 22, 33, 44, 55, 66, 77, 88};
  int t_0im[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int t_1re[8] = '{9, -18, -9, 12, 45, -54, -21, 24};
  int t_1im[8] = '{-3, 6, -27, 36, -15, 18, -63, 72};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    // Twiddle cases and scaling, streamed back-to-back.
    send(pk(100, 50), pk(20, -10), pw(65536, 0), 1'b0, 1'b0, 1'b1, 1'b1, pk(120, 40), pk(80, 60));
    send(pk(100, 50), pk(20, -10), pw(0, -65536), 1'b0, 1'b0, 1'b1, 1'b1, pk(120, 40), pk(60, -80));
    send(pk(100, 50), pk(20, -10), pw(46341, -46341), 1'b0, 1'b0, 1'b1, 1'b1, pk(120, 40), pk(99, -14));
    send(pk(3, -3), pk(0, 0), pw(65536, 0), 1'b0, 1'b1, 1'b1, 1'b1, pk(2, -1), pk(2, -1));
    send(pk(100, 50), pk(20, -10), pw(65536, 0), 1'b0, 1'b0, 1'b1, 1'b1, pk(120, 40), pk(80, 60));
    drain();
    chk("ovf_before_sat", 64'(ovf), 64'(0));

    // Saturation and sticky flag.
    send(pk(16777215, -16777216), pk(16777215, -16777216), pw(65536, 0), 1'b0, 1'b0, 1'b1, 1'b0,
         pk(16777215, -16777216), pk(0, 0));
    drain();
    chk("ovf_set", 64'(ovf), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", 64'(ovf), 64'(1));
    clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'(0));
    send(pk(16777215, -16777216), pk(16777215, -16777216), pw(65536, 0), 1'b0, 1'b1, 1'b1, 1'b0,
         pk(16777215, -16777216), pk(0, 0));
    drain();
    chk("ovf_scaled_none", 64'(ovf), 64'(0));

    // Backpressure: eight pairs, downstream stalls for a window mid-stream.
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(pk(t_are[k], t_aim[k]), pk(t_bre[k], t_bim[k]), pw(t_wre[k], t_wim[k]),
               (k == 7) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0,
               pk(t_0re[k], t_0im[k]), pk(t_1re[k], t_1im[k]));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a saturated, held output and three pairs behind it.
    m_ready = 1'b0;
    send(pk(16777215, -16777216), pk(16777215, -16777216), pw(65536, 0), 1'b1, 1'b0, 1'b0, 1'b0,
         pk(0, 0), pk(0, 0));
    for (int k = 0; k < 3; k++)
      send(pk(t_are[k], t_aim[k]), pk(t_bre[k], t_bim[k]), pw(t_wre[k], t_wim[k]),
           1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0), pk(0, 0));
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("held_valid", 64'(m_valid), 64'(1));
    chk("held_last", 64'(m_last), 64'(1));
    chk("held_ovf", 64'(ovf), 64'(1));
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_m_valid", 64'(m_valid), 64'(0));
    chk("async_m_last", 64'(m_last), 64'(0));
    chk("async_ovf", 64'(ovf), 64'(0));
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    m_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_stale_valid", 64'(m_valid), 64'(0));
    chk("no_stale_queue", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_r2_butterfly.md
Name: fft_r2_butterfly

Overview:
- Parametrised, fully handshaked radix-2 DIF butterfly for the FFT datapath. Each transfer accepts a complex pair (a, b) and a twiddle w, and produces X0 = a+b and X1 = (a-b)*w.
- Adds generic widths, runtime per-stage scaling, saturation with a sticky overflow flag, and valid/ready backpressure with a frame-last tag.
- Intended as the single replicated element from which 8/16/N-point stage pipelines are built.

Parameters:
- DATA_W, 25, bits per real/imag component of data; packed complex word is 2*DATA_W bits, re in the upper half, im in the lower half.
- TW_W, 18, bits per twiddle component (signed).
- TW_FRAC, 16, twiddle fractional bits; 1.0 = 2^TW_FRAC.
- MUL_STAGES, 3, complex multiplier pipeline depth, >=1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- s_valid_i  in  1  input pair valid.
- s_ready_o  out  1  block can accept an input this cycle.
- s_a_i  in  2*DATA_W  operand a {re,im}, signed.
- s_b_i  in  2*DATA_W  operand b {re,im}, signed.
- s_w_i  in  2*TW_W  twiddle {re,im}, signed Q(TW_W-TW_FRAC).TW_FRAC.
- s_last_i  in  1  last pair of a frame.
- scale_i  in  1  1 = divide both outputs by 2 (sampled with the input pair).
- m_valid_o  out  1  output pair valid.
- m_ready_i  in  1  downstream accepts.
- m_x0_o  out  2*DATA_W  a+b {re,im}.
- m_x1_o  out  2*DATA_W  (a-b)*w {re,im}.
- m_last_o  out  1  s_last_i delayed with its pair.
- ovf_o  out  1  sticky: saturation occurred on any component.
- clear_ovf_i  in  1  synchronous clear of ovf_o.

Behaviour:
- Reset (rst_i=0, asynchronous): all pipeline valid bits 0, so m_valid_o=0, m_last_o=0, ovf_o=0. Data registers need no reset; m_x0_o and m_x1_o are don't-care while m_valid_o=0.
- Latency LAT = MUL_STAGES+2 cycles from input acceptance to m_valid_o when unstalled.
  - Stage 0: register inputs, form sum and difference at DATA_W+1 bits.
  - Stages 1..MUL_STAGES: complex multiply.
  - Final stage: round, scale, saturate.
- Throughput: one pair per cycle.
- Handshake:
  - en = !m_valid_o || m_ready_i. All stages advance only when en=1; s_ready_o = en.
  - s_ready_o is combinational from m_ready_i and m_valid_o.
  - Input is accepted when s_valid_i && s_ready_o.
  - Bubbles propagate as valid=0 stages; no bubble collapsing.
  - Outputs are held stable while m_valid_o && !m_ready_i.
- Sum path: X0 is carried in a delay line matched to the multiplier depth, so X0 and X1 of the same pair emerge together. scale_i and s_last_i travel in the same sideband.
- Multiply: d = a-b (DATA_W+1 bits).
  - re = dr*wr - di*wi
  - im = dr*wi + di*wr
  - Full precision is kept; no truncation inside the multiplier.
- Post-processing, per component:
  - X1: add 2^(TW_FRAC-1), then arithmetic shift right by TW_FRAC (round half up).
  - If the pair's scale bit is 1, then on both X0 and X1: add 1, arithmetic shift right by 1.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ovf_o: set the cycle after any component of an output-stage pair saturates; only pairs with valid=1 count.
  - Cleared by clear_ovf_i.
  - Set wins over clear in the same cycle.
- Reset mid-frame: all in-flight data is discarded; there is no partial output after release.
- Twiddle -1.0 (-2^TW_FRAC) is legal. Twiddle magnitude above 2^(TW_W-1)-1 cannot be represented.

Decomposition:
- Package fft_pkg holds:
  - default DATA_W/TW_W/TW_FRAC;
  - packed complex typedef helpers, with functions cplx_re/cplx_im/cplx_pack;
  - functions round_shift and sat, used by every FFT block.
- Sub-module cmult_pipe: MUL_STAGES-deep complex multiplier with valid and enable pins, instantiated once.

Test Plan:
- Identity twiddle: a=(100,50), b=(20,-10), w=(65536,0), scale 0 -> X0=(120,40), X1=(80,60), m_valid_o exactly 5 cycles after acceptance.
- Twiddle -j: same a and b, w=(0,-65536) -> X1=(60,-80). Twiddle (46341,-46341) with d=(80,60) -> X1=(99,-14).
- Scaling and rounding: a=(3,-3), b=(0,0), w=1.0, scale 1 -> X0=(2,-1), X1=(2,-1). Next pair with scale 0 is unaffected.
- Saturation: a=b=(16777215,-16777216), scale 0 -> X0=(16777215,-16777216), ovf_o=1 the following cycle and stays set. Pulse clear_ovf_i -> 0. Repeat with scale 1 -> no overflow.
- Backpressure: stream 8 pairs with m_ready_i low for cycles 3-7 -> s_ready_o low while the output is held, no loss or duplication, order preserved, m_last_o only on pair 8.
- Async reset: assert rst_i with 3 pairs in flight -> m_valid_o=0 and ovf_o=0 immediately (before the next edge), no stale output after release.
